// File: rtl/h_row_streamer.sv
// Purpose: walks sparse matrix H row by row and streams (value, col) pairs with row tags.
// Latency: start -> node_info read +1, first H_data read +3, first element valid +5.
// Backpressure: 2-entry output buffer; reads issue only when a buffer slot is guaranteed.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   start_i                       - begin a pass from row 0 (ignored unless idle)
//   node_info_addr/en/dout        - per-row metadata BRAM {row_length, num_of_nodes, src_flag}
//   h_data_addr/en/dout           - non-zero BRAM {value, col_idx}, 1-cycle read latency
//   elem_valid/ready + elem_*     - output stream of elements with row tags
//   busy_o, done_o, error_o       - pass status; error_o is sticky overflow of H_data
module h_row_streamer #(
    parameter int DATA_WIDTH      = 8,
    parameter int COL_IDX_WIDTH   = 5,
    parameter int ROW_LEN_WIDTH   = 5,
    parameter int NUM_NODE_WIDTH  = 5,
    parameter int H_DATA_DEPTH    = 2105,
    parameter int NODE_INFO_DEPTH = 200,
    localparam int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
    localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    localparam int NODE_INFO_WIDTH  = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1,
    localparam int H_DATA_WIDTH     = DATA_WIDTH + COL_IDX_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic [NODE_INFO_ADDR_W-1:0] node_info_addr_o,
    output logic                        node_info_en_o,
    input  logic [NODE_INFO_WIDTH-1:0]  node_info_dout_i,
    output logic [H_DATA_ADDR_W-1:0]    h_data_addr_o,
    output logic                        h_data_en_o,
    input  logic [H_DATA_WIDTH-1:0]     h_data_dout_i,
    output logic                        elem_valid_o,
    input  logic                        elem_ready_i,
    output logic [DATA_WIDTH-1:0]       elem_value_o,
    output logic [COL_IDX_WIDTH-1:0]    elem_col_o,
    output logic                        elem_last_o,
    output logic [NODE_INFO_ADDR_W-1:0] elem_row_o,
    output logic [NUM_NODE_WIDTH-1:0]   elem_num_nodes_o,
    output logic                        elem_src_flag_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o
);

    // One extra bit so the pointer can sit at H_DATA_DEPTH (overflow marker).
    localparam int H_PTR_W = H_DATA_ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INFO_RD,
        S_INFO_WAIT,
        S_STREAM,
        S_NEXT_ROW,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]       value;
        logic [COL_IDX_WIDTH-1:0]    col;
        logic                        last;
        logic [NODE_INFO_ADDR_W-1:0] row;
        logic [NUM_NODE_WIDTH-1:0]   num_nodes;
        logic                        src_flag;
    } elem_t;

    state_t                      r_state;
    logic [NODE_INFO_ADDR_W-1:0] r_row;
    logic [H_PTR_W-1:0]          r_h_ptr;
    logic [ROW_LEN_WIDTH-1:0]    r_remaining;
    logic [NUM_NODE_WIDTH-1:0]   r_num_nodes;
    logic                        r_src_flag;
    logic                        r_ni_en;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;

    // Slot issued last cycle; its data (BRAM or synthetic zero) is written this cycle.
    logic                        r_pend_vld;
    logic                        r_pend_synth;
    elem_t                       r_pend;

    elem_t                       r_mem [2];
    logic                        r_wr_ptr;
    logic                        r_rd_ptr;
    logic [1:0]                  r_count;

    logic                        w_pop;
    logic [2:0]                  w_occ_sum;
    logic                        w_slot_free;
    logic                        w_issue;
    logic                        w_ovf;
    logic                        w_synth;
    logic                        w_issue_last;
    logic                        w_drained;
    elem_t                       w_wr_elem;
    elem_t                       w_head;

    assign w_pop = (r_count != 2'd0) && elem_ready_i;

    // A slot issued now lands one cycle later; counting this cycle's pop keeps
    // one element per cycle flowing without ever writing a full buffer.
    assign w_occ_sum   = {1'b0, r_count} + {2'b00, r_pend_vld};
    assign w_slot_free = w_occ_sum < (3'd2 + {2'b00, w_pop});
    assign w_issue     = (r_state == S_STREAM) && w_slot_free;

    assign w_ovf        = (r_remaining != '0) && (r_h_ptr == H_PTR_W'(H_DATA_DEPTH));
    // Zero-length rows and overflowing reads both produce a zero element without a BRAM access.
    assign w_synth      = (r_remaining == '0) || w_ovf;
    assign w_issue_last = (r_remaining <= ROW_LEN_WIDTH'(1));

    // Drained when the buffer empties this cycle with nothing left in flight,
    // so done_o lands one cycle after the final handshake.
    assign w_drained = !r_pend_vld &&
                       ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

    always_comb begin
        w_wr_elem = r_pend;
        if (!r_pend_synth) begin
            w_wr_elem.value = h_data_dout_i[H_DATA_WIDTH-1 -: DATA_WIDTH];
            w_wr_elem.col   = h_data_dout_i[COL_IDX_WIDTH-1:0];
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_h_ptr      <= '0;
            r_remaining  <= '0;
            r_num_nodes  <= '0;
            r_src_flag   <= 1'b0;
            r_ni_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_synth <= 1'b0;
            r_pend       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_pend_vld <= w_issue;
            if (w_issue) begin
                r_pend_synth     <= w_synth;
                r_pend.value     <= '0;
                r_pend.col       <= '0;
                r_pend.last      <= w_issue_last;
                r_pend.row       <= r_row;
                r_pend.num_nodes <= r_num_nodes;
                r_pend.src_flag  <= r_src_flag;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_INFO_RD;
                        r_row   <= '0;
                        r_h_ptr <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ni_en <= 1'b1;
                    end
                end
                S_INFO_RD: begin
                    r_ni_en <= 1'b0;
                    r_state <= S_INFO_WAIT;
                end
                S_INFO_WAIT: begin
                    r_remaining <= node_info_dout_i[NODE_INFO_WIDTH-1 -: ROW_LEN_WIDTH];
                    r_num_nodes <= node_info_dout_i[NUM_NODE_WIDTH:1];
                    r_src_flag  <= node_info_dout_i[0];
                    r_state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_issue) begin
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - ROW_LEN_WIDTH'(1);
                        end
                        if (!w_synth) begin
                            r_h_ptr <= r_h_ptr + H_PTR_W'(1);
                        end
                        if (w_ovf) begin
                            r_error <= 1'b1;
                        end
                        if (w_issue_last) begin
                            r_state <= S_NEXT_ROW;
                        end
                    end
                end
                S_NEXT_ROW: begin
                    if (r_row == NODE_INFO_ADDR_W'(NODE_INFO_DEPTH - 1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_row   <= r_row + NODE_INFO_ADDR_W'(1);
                        r_ni_en <= 1'b1;
                        r_state <= S_INFO_RD;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry output buffer; row tags travel with each entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_pend_vld) begin
                r_mem[r_wr_ptr] <= w_wr_elem;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_pend_vld} - {1'b0, w_pop};
        end
    end

    assign node_info_addr_o = r_row;
    assign node_info_en_o   = r_ni_en;
    assign h_data_addr_o    = r_h_ptr[H_DATA_ADDR_W-1:0];
    // Combinational so a read can issue in the same cycle a slot frees up.
    assign h_data_en_o      = w_issue && !w_synth;

    assign elem_valid_o     = (r_count != 2'd0);
    assign elem_value_o     = w_head.value;
    assign elem_col_o       = w_head.col;
    assign elem_last_o      = w_head.last;
    assign elem_row_o       = w_head.row;
    assign elem_num_nodes_o = w_head.num_nodes;
    assign elem_src_flag_o  = w_head.src_flag;

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign error_o = r_error;

endmodule

// File: tb/tb_h_row_streamer.sv
// Purpose: bench for h_row_streamer with BRAM models and an element-list reference.
// Latency: checks start->info read +1, first H read +3, first element +5.
// Backpressure: drives elem_ready_i constant or random and checks stall stability.
module tb_h_row_streamer;

    localparam int ND  = 200;
    localparam int HD  = 2105;
    localparam int HAW = 12;
    localparam int NAW = 8;

    typedef struct packed {
        logic [7:0] value;
        logic [4:0] col;
        logic       last;
        logic [7:0] row;
        logic [4:0] nn;
        logic       flag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [NAW-1:0]  node_info_addr_o;
    logic            node_info_en_o;
    logic [10:0]     node_info_dout_i = '0;
    logic [HAW-1:0]  h_data_addr_o;
    logic            h_data_en_o;
    logic [12:0]     h_data_dout_i = '0;
    logic            elem_valid_o;
    logic            elem_ready_i = 1'b1;
    logic [7:0]      elem_value_o;
    logic [4:0]      elem_col_o;
    logic            elem_last_o;
    logic [NAW-1:0]  elem_row_o;
    logic [4:0]      elem_num_nodes_o;
    logic            elem_src_flag_o;
    logic            busy_o;
    logic            done_o;
    logic            error_o;

    h_row_streamer dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .node_info_addr_o (node_info_addr_o),
        .node_info_en_o   (node_info_en_o),
        .node_info_dout_i (node_info_dout_i),
        .h_data_addr_o    (h_data_addr_o),
        .h_data_en_o      (h_data_en_o),
        .h_data_dout_i    (h_data_dout_i),
        .elem_valid_o     (elem_valid_o),
        .elem_ready_i     (elem_ready_i),
        .elem_value_o     (elem_value_o),
        .elem_col_o       (elem_col_o),
        .elem_last_o      (elem_last_o),
        .elem_row_o       (elem_row_o),
        .elem_num_nodes_o (elem_num_nodes_o),
        .elem_src_flag_o  (elem_src_flag_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    // Matrix contents
    logic [4:0] len_a [ND];
    logic [4:0] nn_a  [ND];
    logic       fl_a  [ND];
    logic [7:0] hv    [HD];
    logic [4:0] hc    [HD];

    // BRAM models, 1-cycle read latency
    always @(posedge clk) begin
        if (node_info_en_o)
            node_info_dout_i <= {len_a[node_info_addr_o], nn_a[node_info_addr_o], fl_a[node_info_addr_o]};
        if (h_data_en_o) begin
            if (int'(h_data_addr_o) < HD) h_data_dout_i <= {hv[h_data_addr_o], hc[h_data_addr_o]};
            else                          h_data_dout_i <= '0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {10'd0, node_info_addr_o, node_info_en_o, h_data_addr_o, h_data_en_o,
                elem_valid_o, elem_value_o, elem_col_o, elem_last_o, elem_row_o,
                elem_num_nodes_o, elem_src_flag_o, busy_o, done_o, error_o};
    endfunction

    // Reference: the ordered list of elements a pass must emit.
    exp_t exp_q[$];
    int   exp_n;
    int   exp_issues;

    task automatic build_model();
        int   ptr;
        exp_t e;
        exp_q.delete();
        ptr = 0;
        exp_issues = 0;
        for (int r = 0; r < ND; r++) begin
            e.row  = 8'(r);
            e.nn   = nn_a[r];
            e.flag = fl_a[r];
            if (len_a[r] == 0) begin
                e.value = 0; e.col = 0; e.last = 1'b1;
                exp_q.push_back(e);
            end else begin
                for (int k = 0; k < int'(len_a[r]); k++) begin
                    e.last = (k == int'(len_a[r]) - 1);
                    if (ptr < HD) begin
                        e.value = hv[ptr]; e.col = hc[ptr];
                        ptr++;
                        exp_issues++;
                    end else begin
                        e.value = 0; e.col = 0;
                    end
                    exp_q.push_back(e);
                end
            end
        end
        exp_n = exp_q.size();
    endtask

    task automatic fill_full(input int total);
        int rem;
        int r;
        for (int i = 0; i < ND; i++) begin
            len_a[i] = 5'd1;
            nn_a[i]  = 5'($urandom);
            fl_a[i]  = 1'($urandom);
        end
        rem = total - ND;
        while (rem > 0) begin
            r = $urandom_range(0, ND - 1);
            if (len_a[r] < 5'd31) begin
                len_a[r] = len_a[r] + 5'd1;
                rem--;
            end
        end
        for (int i = 0; i < HD; i++) begin
            hv[i] = 8'($urandom);
            hc[i] = 5'($urandom_range(0, 19));
        end
    endtask

    // Monitor state
    bit   mon_active = 0;
    bit   rand_mode  = 0;
    bit   prev_stall = 0;
    bit   prev_nl    = 0;
    bit   expect_done = 0;
    bit   done_seen  = 0;
    int   issue_cnt, n_elem, n_last;
    int   first_ni, first_hen, first_vld, start_cyc;
    exp_t prev_dat;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            elem_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        if (mon_active) begin
            cur = {elem_value_o, elem_col_o, elem_last_o, elem_row_o, elem_num_nodes_o, elem_src_flag_o};
            if (node_info_en_o && first_ni < 0) first_ni = cyc;
            if (elem_valid_o && first_vld < 0) first_vld = cyc;
            if (h_data_en_o) begin
                if (first_hen < 0) first_hen = cyc;
                chk("h_addr_seq", 64'(h_data_addr_o), 64'(issue_cnt));
                issue_cnt++;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(elem_valid_o), 64'd1);
                chk("stall_hold", 64'(cur), 64'(prev_dat));
            end
            if (!rand_mode && prev_nl) chk("no_bubble", 64'(elem_valid_o), 64'd1);
            if (expect_done) begin
                chk("done_pulse", 64'(done_o), 64'd1);
                chk("busy_fall", 64'(busy_o), 64'd0);
                expect_done = 0;
                done_seen = 1;
            end else begin
                chk("no_stray_done", 64'(done_o), 64'd0);
            end
            if (elem_valid_o) chk("busy_high", 64'(busy_o), 64'd1);
            prev_stall = elem_valid_o && !elem_ready_i;
            prev_dat   = cur;
            prev_nl    = 0;
            if (elem_valid_o && elem_ready_i) begin
                n_elem++;
                if (elem_last_o) n_last++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("elem", 64'(cur), 64'(e));
                    if (e.last && e.row == 8'(ND - 1)) expect_done = 1;
                    prev_nl = !e.last;
                end
            end
        end
    end

    task automatic do_pass(input bit rr, input bit exp_err, input int abort_row);
        bit found;
        build_model();
        issue_cnt = 0; n_elem = 0; n_last = 0;
        first_ni = -1; first_hen = -1; first_vld = -1;
        prev_stall = 0; prev_nl = 0; expect_done = 0; done_seen = 0;
        rand_mode = rr;
        @(posedge clk);
        #1;
        mon_active = 1;
        start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("err_clear_on_start", 64'(error_o), 64'd0);
        if (abort_row >= 0) begin
            found = 0;
            for (int i = 0; i < 20000 && !found; i++) begin
                @(posedge clk);
                #2;
                if (elem_valid_o && int'(elem_row_o) == abort_row) found = 1;
            end
            chk("abort_row_reached", 64'(found), 64'd1);
            mon_active = 0;
            rand_mode = 0;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("mid_reset_outputs", all_out(), 64'd0);
            rst = 1'b0;
            return;
        end
        for (int i = 0; i < 20000 && !done_seen; i++) @(posedge clk);
        chk("pass_done", 64'(done_seen), 64'd1);
        mon_active = 0;
        rand_mode = 0;
        #1;
        chk("exp_left", 64'(exp_q.size()), 64'd0);
        chk("elem_count", 64'(n_elem), 64'(exp_n));
        chk("last_count", 64'(n_last), 64'(ND));
        chk("error_o", 64'(error_o), 64'(exp_err));
        chk("issue_count", 64'(issue_cnt), 64'(exp_issues));
        chk("lat_info_en", 64'(first_ni - start_cyc), 64'd1);
        chk("lat_h_en", 64'(first_hen - start_cyc), 64'd3);
        chk("lat_valid", 64'(first_vld - start_cyc), 64'd5);
    endtask

    initial begin
        int   lv [5];
        int   lc [5];
        int   ll [5];
        int   lr [5];
        exp_t e;

        fill_full(HD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_out(), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two short rows then zero-length rows
        lv = '{5, 7, 9, 2, 3};
        lc = '{1, 4, 20, 0, 3};
        ll = '{0, 0, 1, 0, 1};
        lr = '{0, 0, 0, 1, 1};
        for (int i = 0; i < ND; i++) len_a[i] = 5'd0;
        len_a[0] = 5'd3;
        len_a[1] = 5'd2;
        for (int i = 0; i < 5; i++) begin
            hv[i] = 8'(lv[i]);
            hc[i] = 5'(lc[i]);
        end
        build_model();
        for (int i = 0; i < 5; i++)
            chk("model_pin_small", 64'({exp_q[i].value, exp_q[i].col, exp_q[i].last, exp_q[i].row}),
                64'({8'(lv[i]), 5'(lc[i]), 1'(ll[i]), 8'(lr[i])}));
        do_pass(0, 0, -1);

        // Zero-length row between two rows of length 2
        fill_full(HD);
        for (int i = 0; i < ND; i++) len_a[i] = 5'd1;
        len_a[0] = 5'd2;
        len_a[1] = 5'd0;
        len_a[2] = 5'd2;
        build_model();
        chk("model_pin_zero_row", 64'({exp_q[2].value, exp_q[2].col, exp_q[2].last, exp_q[2].row}),
            64'({8'd0, 5'd0, 1'b1, 8'd1}));
        chk("model_pin_ptr_kept", 64'({exp_q[3].value, exp_q[3].col}), 64'({hv[2], hc[2]}));
        do_pass(0, 0, -1);

        // Full set, ready high, then the same data under random backpressure
        fill_full(HD);
        do_pass(0, 0, -1);
        do_pass(1, 0, -1);

        // One element more than H_data holds
        fill_full(HD + 1);
        build_model();
        e = exp_q[exp_q.size() - 1];
        chk("model_pin_overflow", 64'({e.value, e.col, e.last, e.row}), 64'({8'd0, 5'd0, 1'b1, 8'(ND - 1)}));
        do_pass(0, 1, -1);

        // Reset in the middle of row 50, then a clean full pass
        fill_full(HD);
        do_pass(0, 0, 50);
        do_pass(0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
